// File: rtl/cfm_pkg.sv
// Shared frame constants and serializer state encoding for the frame serializer slice.
package cfm_pkg;

    localparam int unsigned WORDS     = 20;
    localparam int unsigned DW        = 12;
    localparam int unsigned AW        = 5;
    localparam logic [15:0] SYNC_WORD = 16'hF3A0;

    typedef enum logic [2:0] {
        StIdle,
        StSync,
        StData,
        StPar,
        StEnd
    } ser_state_e;

endpackage

// File: rtl/frame_bank_ram.sv
// Two-bank frame store: one write port and one registered read port.
module frame_bank_ram #(
    parameter int unsigned WORDS = 20,
    parameter int unsigned DW    = 12,
    parameter int unsigned AW    = 5
) (
    input  logic          clk,
    input  logic          wr_bank,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic          we,
    input  logic          rd_bank,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data
);

    logic [DW-1:0] mem [2][WORDS];
    logic [DW-1:0] rd_data_d;
    logic [DW-1:0] rd_data_q;

    always_comb begin
        rd_data_d = mem[rd_bank][rd_addr];
    end

    // Storage is deliberately left without reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_bank][wr_addr] <= wr_data;
        end
        rd_data_q <= rd_data_d;
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/frame_serializer.sv
// Double-buffered frame store feeding a sync-marker + MSB-first bit serializer.
// Define FRAME_SER_PARITY_EN to append an odd-parity bit after every data word.
module frame_serializer #(
    parameter int unsigned WORDS     = cfm_pkg::WORDS,
    parameter int unsigned DW        = cfm_pkg::DW,
    parameter int unsigned BIT_DIV   = 4,
    parameter logic [15:0] SYNC_WORD = cfm_pkg::SYNC_WORD
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [4:0]    wrAdr,
    input  logic          WE,
    input  logic [DW-1:0] dataIn,
    input  logic          full,
    input  logic          clrOvr,
    output logic          sdo,
    output logic          frmStrt,
    output logic          busy,
    output logic          overrun
);
    import cfm_pkg::*;

    localparam int unsigned DivW       = (BIT_DIV > 1) ? $clog2(BIT_DIV) : 1;
    localparam logic [DivW-1:0] DivLast = DivW'(BIT_DIV - 1);
    localparam logic [4:0] BitLast     = 5'(DW - 1);
    localparam logic [4:0] BitPenult   = 5'(DW - 2);
    localparam logic [4:0] WordLast    = 5'(WORDS - 1);

    ser_state_e      state_q, state_d;
    logic [DivW-1:0] div_q, div_d;
    logic [4:0]      bit_cnt_q, bit_cnt_d;
    logic [4:0]      word_cnt_q, word_cnt_d;
    logic            sdo_q, sdo_d;
    logic            frm_strt_q, frm_strt_d;
    logic            busy_q, busy_d;
    logic            overrun_q, overrun_d;
    logic            wr_bank_q, wr_bank_d;
    logic            full_q, full_d;
    logic            start_q, start_d;
`ifdef FRAME_SER_PARITY_EN
    logic            par_q, par_d;
`endif

    logic            full_rise, handoff, ram_we, bit_end;
    logic [DW-1:0]   rd_data, data_shift;
    logic [15:0]     sync_shift;

    assign full_rise = full & ~full_q;
    assign handoff   = full_rise & ~busy_q & ~start_q;
    assign ram_we    = WE & (32'(wrAdr) < WORDS);
    assign bit_end   = (div_q == DivLast);

    frame_bank_ram #(
        .WORDS (WORDS),
        .DW    (DW),
        .AW    (AW)
    ) u_ram (
        .clk     (clk),
        .wr_bank (wr_bank_q),
        .wr_addr (wrAdr),
        .wr_data (dataIn),
        .we      (ram_we),
        .rd_bank (~wr_bank_q),
        .rd_addr (word_cnt_q),
        .rd_data (rd_data)
    );

    always_comb begin
        state_d    = state_q;
        div_d      = div_q;
        bit_cnt_d  = bit_cnt_q;
        word_cnt_d = word_cnt_q;
        sdo_d      = sdo_q;
        frm_strt_d = 1'b0;
        busy_d     = busy_q;
        full_d     = full;
        start_d    = handoff;
        wr_bank_d  = wr_bank_q ^ handoff;
        // A new overrun takes priority over a simultaneous clear.
        overrun_d  = (full_rise & (busy_q | start_q)) ? 1'b1 :
                     (clrOvr ? 1'b0 : overrun_q);
        sync_shift = SYNC_WORD << (bit_cnt_q + 5'd1);
        data_shift = rd_data << (bit_cnt_q + 5'd1);
`ifdef FRAME_SER_PARITY_EN
        par_d      = par_q;
`endif

        if (state_q != StIdle) begin
            div_d = bit_end ? '0 : div_q + DivW'(1);
        end

        case (state_q)
            StIdle: begin
                if (start_q) begin
                    state_d    = StSync;
                    div_d      = '0;
                    bit_cnt_d  = '0;
                    sdo_d      = SYNC_WORD[15];
                    frm_strt_d = 1'b1;
                    busy_d     = 1'b1;
                end
            end
            StSync: begin
                if (bit_end) begin
                    if (bit_cnt_q == 5'd15) begin
                        state_d   = StData;
                        bit_cnt_d = '0;
                        sdo_d     = rd_data[DW-1];
                    end else begin
                        bit_cnt_d = bit_cnt_q + 5'd1;
                        sdo_d     = sync_shift[15];
                    end
                end
            end
            StData: begin
                if (bit_end) begin
                    if (bit_cnt_q == BitLast) begin
                        bit_cnt_d = '0;
`ifdef FRAME_SER_PARITY_EN
                        state_d = StPar;
                        sdo_d   = ~par_q;
`else
                        // Word counter has already wrapped once the last word is out.
                        if (word_cnt_q == '0) begin
                            state_d = StEnd;
                            sdo_d   = 1'b1;
                        end else begin
                            sdo_d = rd_data[DW-1];
                        end
`endif
                    end else begin
                        bit_cnt_d = bit_cnt_q + 5'd1;
                        sdo_d     = data_shift[DW-1];
                        // Advance on entry to the last bit so the next word is read in time.
                        if (bit_cnt_q == BitPenult) begin
                            word_cnt_d = (word_cnt_q == WordLast) ? '0 : word_cnt_q + 5'd1;
                        end
                    end
                end
            end
`ifdef FRAME_SER_PARITY_EN
            StPar: begin
                if (bit_end) begin
                    if (word_cnt_q == '0) begin
                        state_d = StEnd;
                        sdo_d   = 1'b1;
                    end else begin
                        state_d = StData;
                        sdo_d   = rd_data[DW-1];
                    end
                end
            end
`endif
            StEnd: begin
                if (bit_end) begin
                    state_d = StIdle;
                    busy_d  = 1'b0;
                    sdo_d   = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase

`ifdef FRAME_SER_PARITY_EN
        if (bit_end && state_d == StData) begin
            par_d = (state_q == StData) ? (par_q ^ sdo_d) : sdo_d;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= StIdle;
            div_q      <= '0;
            bit_cnt_q  <= '0;
            word_cnt_q <= '0;
            sdo_q      <= 1'b1;
            frm_strt_q <= 1'b0;
            busy_q     <= 1'b0;
            overrun_q  <= 1'b0;
            wr_bank_q  <= 1'b0;
            full_q     <= 1'b0;
            start_q    <= 1'b0;
`ifdef FRAME_SER_PARITY_EN
            par_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            div_q      <= div_d;
            bit_cnt_q  <= bit_cnt_d;
            word_cnt_q <= word_cnt_d;
            sdo_q      <= sdo_d;
            frm_strt_q <= frm_strt_d;
            busy_q     <= busy_d;
            overrun_q  <= overrun_d;
            wr_bank_q  <= wr_bank_d;
            full_q     <= full_d;
            start_q    <= start_d;
`ifdef FRAME_SER_PARITY_EN
            par_q      <= par_d;
`endif
        end
    end

    assign sdo     = sdo_q;
    assign frmStrt = frm_strt_q;
    assign busy    = busy_q;
    assign overrun = overrun_q;

endmodule

// File: tb/tb_frame_serializer.sv
// Scoreboard bench for frame_serializer: stimulus queues expected fields, a monitor decodes sdo.
module tb_frame_serializer;

    localparam int unsigned WORDS   = 20;
    localparam int unsigned DW      = 12;
    localparam int unsigned BIT_DIV = 4;
    localparam logic [15:0] SYNC    = 16'hF3A0;
`ifdef FRAME_SER_PARITY_EN
    localparam int unsigned FRAME_BITS = 16 + WORDS * (DW + 1) + 1;
`else
    localparam int unsigned FRAME_BITS = 16 + WORDS * DW + 1;
`endif

    logic          clk;
    logic          rst;
    logic [4:0]    wrAdr;
    logic          WE;
    logic [DW-1:0] dataIn;
    logic          full;
    logic          clrOvr;
    logic          sdo, frmStrt, busy, overrun;

    typedef struct {
        string       nm;
        int          width;
        logic [31:0] val;
        bit          last;
    } item_t;

    item_t         sb[$];
    logic [DW-1:0] mdl [2][WORDS];
    int            mdl_wb;
    int            n_vec;
    int            n_err;
    int            frames_done;

    frame_serializer dut (
        .clk     (clk),
        .rst     (rst),
        .wrAdr   (wrAdr),
        .WE      (WE),
        .dataIn  (dataIn),
        .full    (full),
        .clrOvr  (clrOvr),
        .sdo     (sdo),
        .frmStrt (frmStrt),
        .busy    (busy),
        .overrun (overrun)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic push_frame(input int bank);
        sb.push_back('{"sync", 16, 32'(SYNC), 1'b0});
        for (int w = 0; w < WORDS; w++) begin
            sb.push_back('{$sformatf("word%0d", w), DW, 32'(mdl[bank][w]), 1'b0});
`ifdef FRAME_SER_PARITY_EN
            sb.push_back('{$sformatf("par%0d", w), 1, 32'(~^mdl[bank][w]), 1'b0});
`endif
        end
        sb.push_back('{"stop", 1, 32'd1, 1'b1});
    endtask

    // ---------------- monitor ----------------
    task automatic wait_bit(inout bit ab, inout int bcnt);
        repeat (BIT_DIV) begin
            @(negedge clk);
            if (!rst) ab = 1'b1;
            if (busy) bcnt++;
        end
    endtask

    task automatic run_frame();
        item_t       it;
        logic [31:0] acc;
        bit          ab;
        int          bcnt;
        ab   = 1'b0;
        bcnt = 1;
        forever begin
            n_vec++;
            if (sb.size() == 0) begin
                n_err++;
                $display("FAIL frame_start: got frmStrt, expected no frame pending");
                return;
            end
            it  = sb.pop_front();
            acc = '0;
            for (int b = 0; b < it.width; b++) begin
                acc = {acc[30:0], sdo};
                wait_bit(ab, bcnt);
                if (ab) return;
            end
            check(it.nm, acc, it.val);
            if (it.last) break;
        end
        check("busy_len", 32'(bcnt), 32'(FRAME_BITS * BIT_DIV));
        frames_done++;
    endtask

    initial begin : monitor
        forever begin
            @(negedge clk);
            if (rst && frmStrt) run_frame();
        end
    end

    // ---------------- stimulus ----------------
    task automatic write_word(input logic [4:0] a, input logic [DW-1:0] d);
        @(posedge clk);
        #1;
        WE     = 1'b1;
        wrAdr  = a;
        dataIn = d;
        if (int'(a) < WORDS) mdl[mdl_wb][a] = d;
        @(posedge clk);
        #1;
        WE = 1'b0;
    endtask

    task automatic fire_frame(input bit with_wr, input logic [4:0] a, input logic [DW-1:0] d);
        @(posedge clk);
        #1;
        full = 1'b1;
        if (with_wr) begin
            WE     = 1'b1;
            wrAdr  = a;
            dataIn = d;
            if (int'(a) < WORDS) mdl[mdl_wb][a] = d;
        end
        push_frame(mdl_wb);
        mdl_wb = mdl_wb ^ 1;
        @(posedge clk);
        #1;
        WE = 1'b0;
        @(negedge clk);
        check("frmStrt_early", frmStrt, 1'b0);
        @(negedge clk);
        check("frmStrt_lat2", frmStrt, 1'b1);
        check("busy_rise", busy, 1'b1);
        @(posedge clk);
        #1;
        full = 1'b0;
    endtask

    task automatic wait_frames(input int target);
        for (int i = 0; i < 3000 && frames_done < target; i++) @(negedge clk);
        check("frames_done", 32'(frames_done), 32'(target));
        @(negedge clk);
        check("idle_sdo", sdo, 1'b1);
        check("idle_busy", busy, 1'b0);
    endtask

    initial begin : stimulus
        n_vec = 0; n_err = 0; frames_done = 0; mdl_wb = 0;
        rst = 1'b0; WE = 1'b0; wrAdr = '0; dataIn = '0; full = 1'b0; clrOvr = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_sdo", sdo, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_frmStrt", frmStrt, 1'b0);
        check("rst_overrun", overrun, 1'b0);
        @(posedge clk);
        #1 rst = 1'b1;

        // Frame A: word i = i
        for (int w = 0; w < WORDS; w++) write_word(5'(w), DW'(w));
        fire_frame(1'b0, '0, '0);
        wait_frames(1);

        // Frame B, with overrun handling about 200 clocks in
        for (int w = 0; w < WORDS; w++) write_word(5'(w), 12'h100 + DW'(w) * 12'h0B7);
        fire_frame(1'b0, '0, '0);
        repeat (190) @(posedge clk);
        for (int w = 0; w < 5; w++) write_word(5'(w), 12'hA00 + DW'(w));
        @(posedge clk);
        #1 full = 1'b1;
        @(negedge clk);
        check("ovr_before_edge", overrun, 1'b0);
        @(posedge clk);
        #1 full = 1'b0;
        @(negedge clk);
        check("ovr_set", overrun, 1'b1);
        @(posedge clk);
        #1 begin full = 1'b1; clrOvr = 1'b1; end
        @(posedge clk);
        #1 begin full = 1'b0; clrOvr = 1'b0; end
        @(negedge clk);
        check("ovr_set_wins", overrun, 1'b1);
        @(posedge clk);
        #1 clrOvr = 1'b1;
        @(posedge clk);
        #1 clrOvr = 1'b0;
        @(negedge clk);
        check("ovr_clr", overrun, 1'b0);
        wait_frames(2);

        // Frame C: out-of-range write ignored, word 19 written with the full edge
        write_word(5'd25, 12'hFFF);
        fire_frame(1'b1, 5'd19, 12'h5C3);
        wait_frames(3);

        // Frame D: reset about 100 bits in
        fire_frame(1'b0, '0, '0);
        repeat (100 * BIT_DIV - 3) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        check("midrst_sdo", sdo, 1'b1);
        check("midrst_busy", busy, 1'b0);
        check("midrst_frmStrt", frmStrt, 1'b0);
        mdl_wb = 0;
        repeat (6) @(posedge clk);
        sb.delete();
        @(negedge clk);
        check("midrst_busy_hold", busy, 1'b0);
        @(posedge clk);
        #1 rst = 1'b1;

        // Frame E: first frame after reset comes from bank 0
        fire_frame(1'b0, '0, '0);
        wait_frames(4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
